// File: rtl/miner_controller_if.sv
// Host, timer and hash-core signals of the mining controller, bundled as one bus.
// master = controller side, slave = environment (host, shift timer, hash core).
interface miner_controller_if #(
    parameter int NONCE_W = 32
);
    logic               start;
    logic               abort;
    logic               midstate_shifts_done;
    logic               remaining_shifts_done;
    logic               hash_done;
    logic               hash_found;
    logic               result_ack;
    logic [2:0]         controller_state;
    logic               shift_enable;
    logic               shift_sel;
    logic               hash_start;
    logic [NONCE_W-1:0] nonce;
    logic               result_valid;
    logic               result_found;
    logic               error;
    logic               busy;

    modport master (
        input  start, abort, midstate_shifts_done, remaining_shifts_done,
               hash_done, hash_found, result_ack,
        output controller_state, shift_enable, shift_sel, hash_start, nonce,
               result_valid, result_found, error, busy
    );

    modport slave (
        output start, abort, midstate_shifts_done, remaining_shifts_done,
               hash_done, hash_found, result_ack,
        input  controller_state, shift_enable, shift_sel, hash_start, nonce,
               result_valid, result_found, error, busy
    );
endinterface

// File: rtl/miner_controller.sv
// Sequencing FSM for one mining pass: load midstate, load remaining words,
// sweep nonces on the hash core, then hold the result for the host.
module miner_controller #(
    parameter int                 NONCE_W      = 32,
    parameter logic [NONCE_W-1:0] NONCE_LAST   = {NONCE_W{1'b1}},
    parameter int                 LOAD_TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    miner_controller_if.master bus
);
    // Host result handshake: result_valid stays high with nonce/result_found
    // stable until the cycle result_ack is sampled high; it drops on the next cycle.
    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        LOAD_MID = 3'b001,
        LOAD_REM = 3'b010,
        HASH     = 3'b011,
        REPORT   = 3'b100,
        MID_HOLD = 3'b101,
        ERROR    = 3'b111
    } state_t;

    localparam int                DW           = $clog2(LOAD_TIMEOUT) + 1;
    localparam logic [DW-1:0]     TIMEOUT_LAST = DW'(LOAD_TIMEOUT - 1);

    state_t             state, state_next;
    logic [NONCE_W-1:0] nonce, nonce_next;
    logic               found, found_next;
    logic               launch, launch_next;
    logic [DW-1:0]      dwell;
    logic               timeout;
    logic               in_load;

    assign in_load = (state == LOAD_MID) || (state == LOAD_REM);
    assign timeout = in_load && (dwell == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            nonce  <= '0;
            found  <= 1'b0;
            launch <= 1'b0;
            dwell  <= '0;
        end else begin
            state  <= state_next;
            nonce  <= nonce_next;
            found  <= found_next;
            launch <= launch_next;
            // Dwell counts cycles spent in the current load state only.
            if (state_next != state || !in_load) dwell <= '0;
            else                                 dwell <= dwell + 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        nonce_next  = nonce;
        found_next  = found;
        launch_next = 1'b0;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_next = LOAD_MID;
                        nonce_next = '0;
                    end
                end
                LOAD_MID: begin
                    if (timeout)                       state_next = ERROR;
                    else if (bus.midstate_shifts_done) state_next = MID_HOLD;
                end
                MID_HOLD: state_next = LOAD_REM;
                LOAD_REM: begin
                    if (timeout) begin
                        state_next = ERROR;
                    end else if (bus.remaining_shifts_done) begin
                        state_next  = HASH;
                        launch_next = 1'b1;
                    end
                end
                HASH: begin
                    // hash_done may coincide with hash_start; it is processed either way.
                    if (bus.hash_done) begin
                        if (bus.hash_found) begin
                            state_next = REPORT;
                            found_next = 1'b1;
                        end else if (nonce == NONCE_LAST) begin
                            state_next = REPORT;
                            found_next = 1'b0;
                        end else begin
                            nonce_next  = nonce + 1'b1;
                            launch_next = 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (bus.result_ack) state_next = IDLE;
                end
                ERROR:   state_next = ERROR;
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.controller_state = state;
    assign bus.shift_enable     = in_load;
    assign bus.shift_sel        = (state == LOAD_REM);
    assign bus.hash_start       = (state == HASH) && launch;
    assign bus.nonce            = nonce;
    assign bus.result_valid     = (state == REPORT);
    assign bus.result_found     = found;
    assign bus.error            = (state == ERROR);
    assign bus.busy             = (state != IDLE) && (state != ERROR);
endmodule

// File: tb/tb_miner_controller.sv
// Directed bench for miner_controller with a small shift-timer model and a
// scripted hash core; NONCE_W=4 so the full nonce range can be swept.
module tb_miner_controller;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    miner_controller_if #(.NONCE_W(NW)) bus ();

    miner_controller #(
        .NONCE_W     (NW),
        .NONCE_LAST  (4'hF),
        .LOAD_TIMEOUT(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Timer model: done after 8 cycles in 001, after 16 cycles in 010.
    logic       timer_en = 1'b0;
    logic [4:0] tcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) tcnt <= '0;
        else if (bus.controller_state == 3'b001 || bus.controller_state == 3'b010) tcnt <= tcnt + 1'b1;
        else tcnt <= '0;
    end
    assign bus.midstate_shifts_done  = timer_en && (bus.controller_state == 3'b001) && (tcnt == 5'd7);
    assign bus.remaining_shifts_done = timer_en && (bus.controller_state == 3'b010) && (tcnt == 5'd15);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, output bit ok);
        int i = 0;
        while (bus.controller_state !== code && i < budget) begin
            step();
            i++;
        end
        ok = (bus.controller_state === code);
    endtask

    // Hash core: done arrives 2 cycles after each hash_start; found when nonce == found_at.
    task automatic run_hash(input int found_at, output int attempts, output int seq_err);
        logic [NW-1:0] want;
        attempts = 0;
        seq_err  = 0;
        for (int g = 0; g < 40 && bus.controller_state == 3'b011; g++) begin
            want = attempts[NW-1:0];
            if (bus.hash_start !== 1'b1 || bus.nonce !== want) seq_err++;
            attempts++;
            step();
            if (bus.hash_start !== 1'b0) seq_err++;
            step();
            bus.hash_done  = 1'b1;
            bus.hash_found = (int'(bus.nonce) == found_at);
            step();
            bus.hash_done  = 1'b0;
            bus.hash_found = 1'b0;
        end
    endtask

    function automatic logic [11:0] outs();
        return {bus.controller_state, bus.shift_enable, bus.shift_sel, bus.hash_start,
                bus.result_valid, bus.result_found, bus.error, bus.busy, bus.nonce[1:0]};
    endfunction

    task automatic test_reset();
        step();
        total++;
        if (outs() !== 12'h000 || bus.nonce !== 4'h0) begin
            bad++; $display("FAIL reset_outputs: got %h nonce %h want 000 nonce 0", outs(), bus.nonce);
        end
        rst = 1'b0;
        step();
        total++;
        if (bus.controller_state !== 3'b000) begin
            bad++; $display("FAIL reset_idle: got %b want 000", bus.controller_state);
        end
    endtask

    task automatic test_load();
        int miss = 0;
        timer_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (bus.controller_state !== 3'b001 || bus.shift_enable !== 1'b1 || bus.shift_sel !== 1'b0) miss++;
            bus.start = (i == 3);  // start while busy must be ignored
            step();
        end
        bus.start = 1'b0;
        total++;
        if (miss != 0) begin
            bad++; $display("FAIL load_mid_8_cycles: got %0d bad cycles want 0", miss);
        end
        total++;
        if (bus.controller_state !== 3'b101 || bus.shift_enable !== 1'b0) begin
            bad++; $display("FAIL mid_hold: got %b en %b want 101 en 0", bus.controller_state, bus.shift_enable);
        end
        step();
        total++;
        if (bus.controller_state !== 3'b010 || bus.shift_sel !== 1'b1 || bus.shift_enable !== 1'b1) begin
            bad++; $display("FAIL load_rem_entry: got %b sel %b want 010 sel 1", bus.controller_state, bus.shift_sel);
        end
        miss = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.controller_state !== 3'b010) miss++;
            step();
        end
        total++;
        if (miss != 0 || bus.controller_state !== 3'b011 || bus.hash_start !== 1'b1) begin
            bad++; $display("FAIL load_rem_16_cycles: got %0d bad, state %b start %b want 0 011 1", miss, bus.controller_state, bus.hash_start);
        end
    endtask

    task automatic test_full_pass();
        int att, se;
        int hold_err = 0;
        run_hash(3, att, se);
        total++;
        if (att != 4 || se != 0) begin
            bad++; $display("FAIL pass_attempts: got %0d attempts %0d seq errs want 4 0", att, se);
        end
        total++;
        if (bus.controller_state !== 3'b100 || bus.nonce !== 4'd3 || bus.result_found !== 1'b1 || bus.result_valid !== 1'b1) begin
            bad++; $display("FAIL pass_report: got st %b nonce %0d found %b valid %b want 100 3 1 1",
                            bus.controller_state, bus.nonce, bus.result_found, bus.result_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.result_valid !== 1'b1 || bus.nonce !== 4'd3 || bus.result_found !== 1'b1) hold_err++;
        end
        total++;
        if (hold_err != 0) begin
            bad++; $display("FAIL pass_hold: got %0d unstable cycles want 0", hold_err);
        end
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
        total++;
        if (bus.controller_state !== 3'b000 || bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL pass_ack: got st %b valid %b busy %b want 000 0 0", bus.controller_state, bus.result_valid, bus.busy);
        end
    endtask

    task automatic test_exhaust();
        bit ok;
        int att, se;
        pulse_start();
        wait_state(3'b011, 60, ok);
        run_hash(-1, att, se);
        total++;
        if (!ok || att != 16 || se != 0) begin
            bad++; $display("FAIL exhaust_attempts: got ok %0d attempts %0d seq errs %0d want 1 16 0", ok, att, se);
        end
        total++;
        if (bus.controller_state !== 3'b100 || bus.nonce !== 4'd15 || bus.result_found !== 1'b0) begin
            bad++; $display("FAIL exhaust_report: got st %b nonce %0d found %b want 100 15 0", bus.controller_state, bus.nonce, bus.result_found);
        end
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
    endtask

    task automatic test_same_cycle_done();
        bit ok;
        pulse_start();
        wait_state(3'b011, 60, ok);
        bus.hash_done = 1'b1;  // coincident with the first hash_start, not found
        bus.hash_found = 1'b0;
        step();
        total++;
        if (!ok || bus.controller_state !== 3'b011 || bus.hash_start !== 1'b1 || bus.nonce !== 4'd1) begin
            bad++; $display("FAIL same_cycle_step: got ok %0d st %b start %b nonce %0d want 1 011 1 1", ok, bus.controller_state, bus.hash_start, bus.nonce);
        end
        bus.hash_found = 1'b1;
        step();
        bus.hash_done = 1'b0;
        bus.hash_found = 1'b0;
        total++;
        if (bus.controller_state !== 3'b100 || bus.nonce !== 4'd1 || bus.result_found !== 1'b1) begin
            bad++; $display("FAIL same_cycle_found: got st %b nonce %0d found %b want 100 1 1", bus.controller_state, bus.nonce, bus.result_found);
        end
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int miss = 0;
        timer_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            if (bus.controller_state !== 3'b001) miss++;
            step();
        end
        total++;
        if (miss != 0 || bus.controller_state !== 3'b111 || bus.error !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL timeout: got %0d early, st %b err %b busy %b want 0 111 1 0", miss, bus.controller_state, bus.error, bus.busy);
        end
        step();
        step();
        total++;
        if (bus.controller_state !== 3'b111 || bus.error !== 1'b1) begin
            bad++; $display("FAIL error_sticky: got st %b err %b want 111 1", bus.controller_state, bus.error);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        total++;
        if (bus.controller_state !== 3'b000 || bus.error !== 1'b0) begin
            bad++; $display("FAIL error_abort: got st %b err %b want 000 0", bus.controller_state, bus.error);
        end
        timer_en = 1'b1;
    endtask

    task automatic test_abort_hash();
        bit ok;
        pulse_start();
        wait_state(3'b011, 60, ok);
        bus.abort = 1'b1;
        bus.hash_done = 1'b1;
        bus.hash_found = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.hash_done = 1'b0;
        bus.hash_found = 1'b0;
        step();
        total++;
        if (!ok || bus.controller_state !== 3'b000 || bus.result_valid !== 1'b0 || bus.nonce !== 4'd0 || bus.hash_start !== 1'b0) begin
            bad++; $display("FAIL abort_hash: got ok %0d st %b valid %b nonce %0d start %b want 1 000 0 0 0",
                            ok, bus.controller_state, bus.result_valid, bus.nonce, bus.hash_start);
        end
    endtask

    task automatic test_ignored_inputs();
        bus.hash_done = 1'b1;
        bus.hash_found = 1'b1;
        step();
        bus.hash_done = 1'b0;
        bus.hash_found = 1'b0;
        step();
        total++;
        if (bus.controller_state !== 3'b000 || bus.nonce !== 4'd0 || bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL idle_hash_done: got st %b nonce %0d valid %b want 000 0 0", bus.controller_state, bus.nonce, bus.result_valid);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        pulse_start();
        wait_state(3'b010, 40, ok);
        step();
        step();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if (!ok || outs() !== 12'h000 || bus.nonce !== 4'h0) begin
            bad++; $display("FAIL async_reset: got ok %0d outs %h want 1 000", ok, outs());
        end
        #1 rst = 1'b0;
        step();
        total++;
        if (bus.controller_state !== 3'b000 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL after_reset: got st %b busy %b want 000 0", bus.controller_state, bus.busy);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.hash_done  = 1'b0;
        bus.hash_found = 1'b0;
        bus.result_ack = 1'b0;
        test_reset();
        test_load();
        test_full_pass();
        test_exhaust();
        test_same_cycle_done();
        test_timeout();
        test_abort_hash();
        test_ignored_inputs();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
